// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Digit record layout and active-low hex segment table.
package smg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] value;
  } digit_t;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  // Index 0 sits in the low byte: entries run F..0 from MSB to LSB.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/smg_seg_encode.sv
// Digit record to active-low {dp,g,f,e,d,c,b,a} pattern.
// Purely combinational; blank digits drive all segments off.
module smg_seg_encode
  import smg_pkg::*;
(
  input  digit_t     dig_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dig_i.en) begin
      seg_o = SEG_HEX[dig_i.value];
      if (dig_i.dp) begin
        seg_o[7] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/smg_display_ctrl.sv
// Scan strobe, two-port round-robin digit writer and
// tear-free frame commit for the 6-digit scanner.
module smg_display_ctrl
  import smg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
)
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_valid_i,
  input  logic [2:0] a_digit_i,
  input  logic [3:0] a_value_i,
  input  logic       a_dp_i,
  input  logic       a_en_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic [2:0] b_digit_i,
  input  logic [3:0] b_value_i,
  input  logic       b_dp_i,
  input  logic       b_en_i,
  output logic       b_ready_o,
  output logic       scan_tick_o,
  output logic [2:0] scan_idx_o,
  output logic       frame_commit_o,
  output logic [7:0] smg_1_o,
  output logic [7:0] smg_2_o,
  output logic [7:0] smg_3_o,
  output logic [7:0] smg_4_o,
  output logic [7:0] smg_5_o,
  output logic [7:0] smg_6_o
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX =
    CW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_LIM =
    IDX_W'(NUM_DIGITS);

  logic [CW-1:0]    div_cnt;
  logic [IDX_W-1:0] scan_idx;
  ptr_e             ptr;
  logic             dirty;

  digit_t     shadow_q [NUM_DIGITS];
  digit_t     disp_q   [NUM_DIGITS];
  digit_t     disp_d   [NUM_DIGITS];
  logic [7:0] seg_d    [NUM_DIGITS];
  logic [7:0] seg_q    [NUM_DIGITS];

  logic             tick;
  logic             frame_end;
  logic             commit;
  logic             wr_en;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_digit;
  digit_t           wr_rec;

  assign tick      = (div_cnt == DIV_MAX);
  assign frame_end = tick & (scan_idx == IDX_LAST);
  assign commit    = frame_end & dirty;

  assign a_ready_o = a_valid_i &
                     (~b_valid_i | (ptr == PTR_A));
  assign b_ready_o = b_valid_i &
                     (~a_valid_i | (ptr == PTR_B));

  assign wr_en = a_ready_o | b_ready_o;

  always_comb begin
    wr_digit     = b_digit_i;
    wr_rec.en    = b_en_i;
    wr_rec.dp    = b_dp_i;
    wr_rec.value = b_value_i;
    if (a_ready_o) begin
      wr_digit     = a_digit_i;
      wr_rec.en    = a_en_i;
      wr_rec.dp    = a_dp_i;
      wr_rec.value = a_value_i;
    end
  end

  // Out-of-range digits are acknowledged but discarded.
  assign wr_ok = wr_en & (wr_digit < IDX_LIM);

  // Commit sees the shadow before this cycle's write lands.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      disp_d[i] = commit ? shadow_q[i] : disp_q[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    smg_seg_encode u_enc (
      .dig_i (disp_d[g]),
      .seg_o (seg_d[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ?
                  '0 : scan_idx + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr <= PTR_A;
    end else if (a_valid_i & b_valid_i) begin
      ptr <= a_ready_o ? PTR_B : PTR_A;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dirty <= 1'b0;
    end else if (wr_ok) begin
      dirty <= 1'b1;
    end else if (commit) begin
      dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
        seg_q[i]    <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_ok && (wr_digit == IDX_W'(i))) begin
          shadow_q[i] <= wr_rec;
        end
        disp_q[i] <= disp_d[i];
        seg_q[i]  <= seg_d[i];
      end
    end
  end

  assign scan_tick_o    = tick;
  assign scan_idx_o     = scan_idx;
  assign frame_commit_o = commit;

  assign smg_1_o = seg_q[0];
  assign smg_2_o = seg_q[1];
  assign smg_3_o = seg_q[2];
  assign smg_4_o = seg_q[3];
  assign smg_5_o = seg_q[4];
  assign smg_6_o = seg_q[5];

endmodule

// File: tb/tb_smg_display_ctrl.sv
// Bench for smg_display_ctrl: frame-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_smg_display_ctrl;

  localparam int DIV = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       a_valid_i = 1'b0;
  logic [2:0] a_digit_i = '0;
  logic [3:0] a_value_i = '0;
  logic       a_dp_i = 1'b0;
  logic       a_en_i = 1'b0;
  logic       a_ready_o;
  logic       b_valid_i = 1'b0;
  logic [2:0] b_digit_i = '0;
  logic [3:0] b_value_i = '0;
  logic       b_dp_i = 1'b0;
  logic       b_en_i = 1'b0;
  logic       b_ready_o;
  logic       scan_tick_o;
  logic [2:0] scan_idx_o;
  logic       frame_commit_o;
  logic [7:0] smg_1_o, smg_2_o, smg_3_o;
  logic [7:0] smg_4_o, smg_5_o, smg_6_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  smg_display_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .a_valid_i      (a_valid_i),
    .a_digit_i      (a_digit_i),
    .a_value_i      (a_value_i),
    .a_dp_i         (a_dp_i),
    .a_en_i         (a_en_i),
    .a_ready_o      (a_ready_o),
    .b_valid_i      (b_valid_i),
    .b_digit_i      (b_digit_i),
    .b_value_i      (b_value_i),
    .b_dp_i         (b_dp_i),
    .b_en_i         (b_en_i),
    .b_ready_o      (b_ready_o),
    .scan_tick_o    (scan_tick_o),
    .scan_idx_o     (scan_idx_o),
    .frame_commit_o (frame_commit_o),
    .smg_1_o        (smg_1_o),
    .smg_2_o        (smg_2_o),
    .smg_3_o        (smg_3_o),
    .smg_4_o        (smg_4_o),
    .smg_5_o        (smg_5_o),
    .smg_6_o        (smg_6_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: digit records are {en,dp,value}.
  logic [7:0] seg_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] enc(input logic [5:0] r);
    logic [7:0] s;
    if (!r[5]) return 8'hFF;
    s = seg_tbl[r[3:0]];
    if (r[4]) s = s & 8'h7F;
    return s;
  endfunction

  int         m_cnt;
  logic [2:0] m_idx;
  bit         m_ptr;
  bit         m_dirty;
  logic [5:0] m_sh   [6];
  logic [5:0] m_disp [6];
  logic [7:0] m_seg  [6];

  bit         e_tick, e_commit, e_ar, e_br, n_dirty;
  logic [5:0] n_sh   [6];
  logic [5:0] n_disp [6];

  always_comb begin
    e_tick   = (m_cnt == DIV - 1);
    e_commit = e_tick && (m_idx == 3'd5) && m_dirty;
    e_ar = a_valid_i && (!b_valid_i || !m_ptr);
    e_br = b_valid_i && (!a_valid_i || m_ptr);
    n_dirty = m_dirty && !e_commit;
    for (int k = 0; k < 6; k++) begin
      n_sh[k]   = m_sh[k];
      n_disp[k] = e_commit ? m_sh[k] : m_disp[k];
      if (e_ar && a_digit_i == 3'(k)) begin
        n_sh[k] = {a_en_i, a_dp_i, a_value_i};
        n_dirty = 1'b1;
      end else if (e_br && b_digit_i == 3'(k)) begin
        n_sh[k] = {b_en_i, b_dp_i, b_value_i};
        n_dirty = 1'b1;
      end
    end
  end

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_cnt   <= 0;
      m_idx   <= '0;
      m_ptr   <= 1'b0;
      m_dirty <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        m_sh[k]   <= '0;
        m_disp[k] <= '0;
        m_seg[k]  <= 8'hFF;
      end
    end else begin
      m_cnt   <= (m_cnt + 1) % DIV;
      if (e_tick) m_idx <= (m_idx == 3'd5) ? 3'd0 : m_idx + 3'd1;
      if (a_valid_i && b_valid_i) m_ptr <= e_ar;
      m_dirty <= n_dirty;
      for (int k = 0; k < 6; k++) begin
        m_sh[k]   <= n_sh[k];
        m_disp[k] <= n_disp[k];
        m_seg[k]  <= enc(n_disp[k]);
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("tick", scan_tick_o, e_tick);
      chk("idx", scan_idx_o, m_idx);
      chk("commit", frame_commit_o, e_commit);
      chk("a_ready", a_ready_o, e_ar);
      chk("b_ready", b_ready_o, e_br);
      chk("smg",
          {smg_6_o, smg_5_o, smg_4_o, smg_3_o, smg_2_o, smg_1_o},
          {m_seg[5], m_seg[4], m_seg[3],
           m_seg[2], m_seg[1], m_seg[0]});
    end
  end

  task automatic wr_a(input logic [2:0] d, input logic [3:0] v,
                      input logic dp, input logic en);
    @(posedge clk_i); #1;
    a_valid_i = 1'b1; a_digit_i = d; a_value_i = v;
    a_dp_i = dp; a_en_i = en;
    @(negedge clk_i);
    chk("wr_a_ready", a_ready_o, 1'b1);
    @(posedge clk_i); #1;
    a_valid_i = 1'b0;
  endtask

  task automatic wait_commit(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_i);
      if (frame_commit_o) found = 1'b1;
    end
    chk(nm, found, 1'b1);
  endtask

  task automatic count_events(input int n, output int ticks,
                              output int commits);
    ticks = 0; commits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (scan_tick_o) ticks++;
      if (frame_commit_o) commits++;
    end
  endtask

  initial begin
    int tk, cm;
    logic [3:0] ga, gb;
    bit aligned;

    // 1: reset and idle scanning
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);
    chk("rst_smg",
        {smg_6_o, smg_5_o, smg_4_o, smg_3_o, smg_2_o, smg_1_o},
        48'hFFFF_FFFF_FFFF);
    chk("rst_idx", scan_idx_o, 3'd0);
    count_events(24, tk, cm);
    chk("idle_ticks", tk, 6);
    chk("idle_commits", cm, 0);

    // 2: single write from A
    wr_a(3'd2, 4'h8, 1'b0, 1'b1);
    wait_commit("t2_commit");
    @(negedge clk_i);
    chk("t2_smg3", smg_3_o, 8'h80);
    count_events(24, tk, cm);
    chk("t2_no_repeat", cm, 0);

    // 3: contention alternates grants
    @(posedge clk_i); #1;
    a_valid_i = 1'b1; a_digit_i = 3'd0; a_value_i = 4'h5;
    a_dp_i = 1'b0; a_en_i = 1'b1;
    b_valid_i = 1'b1; b_digit_i = 3'd1; b_value_i = 4'hA;
    b_dp_i = 1'b1; b_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      ga[i] = a_ready_o;
      gb[i] = b_ready_o;
      @(posedge clk_i); #1;
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    chk("t3_a_grants", ga, 4'b0101);
    chk("t3_b_grants", gb, 4'b1010);
    wait_commit("t3_commit");
    @(negedge clk_i);
    chk("t3_smg1", smg_1_o, 8'h92);
    chk("t3_smg2", smg_2_o, 8'h08);

    // 4: write landing on the frame-end tick
    wr_a(3'd4, 4'h0, 1'b0, 1'b1);
    aligned = 1'b0;
    for (int i = 0; i < 40 && !aligned; i++) begin
      @(negedge clk_i);
      if (m_idx == 3'd5 && m_cnt == DIV - 2) aligned = 1'b1;
    end
    chk("t4_align", aligned, 1'b1);
    @(posedge clk_i); #1;
    b_valid_i = 1'b1; b_digit_i = 3'd5; b_value_i = 4'h3;
    b_dp_i = 1'b1; b_en_i = 1'b1;
    @(negedge clk_i);
    chk("t4_b_ready", b_ready_o, 1'b1);
    chk("t4_commit_now", frame_commit_o, 1'b1);
    @(posedge clk_i); #1;
    b_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_smg5", smg_5_o, 8'hC0);
    chk("t4_smg6_old", smg_6_o, 8'hFF);
    wait_commit("t4_commit_next");
    @(negedge clk_i);
    chk("t4_smg6", smg_6_o, 8'h30);

    // 5: out-of-range digit is dropped
    wr_a(3'd7, 4'h1, 1'b0, 1'b1);
    count_events(30, tk, cm);
    chk("t5_commits", cm, 0);
    chk("t5_smg",
        {smg_6_o, smg_5_o, smg_4_o, smg_3_o, smg_2_o, smg_1_o},
        48'h30C0FF800892);

    // 6: reset mid-frame discards pending writes
    wr_a(3'd0, 4'h0, 1'b0, 1'b1);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_smg_rst",
        {smg_6_o, smg_5_o, smg_4_o, smg_3_o, smg_2_o, smg_1_o},
        48'hFFFF_FFFF_FFFF);
    chk("t6_idx", scan_idx_o, 3'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    count_events(60, tk, cm);
    chk("t6_commits", cm, 0);
    chk("t6_smg_after",
        {smg_6_o, smg_5_o, smg_4_o, smg_3_o, smg_2_o, smg_1_o},
        48'hFFFF_FFFF_FFFF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smg_display_ctrl.md
# smg_display_ctrl

Sequencing and sharing controller for the 6-digit seven-segment scanner. It generates the one-cycle digit-advance strobe that drives the scanner's `p1pps` input. It arbitrates digit writes from two independent requesters into a shadow frame buffer and commits that buffer at frame boundaries, so the display never tears. Its registered, encoded segment patterns feed the scanner's `smg_1_i`..`smg_6_i` inputs directly.

## Interface
- `SCAN_DIV`, default 50000: clk_i cycles per digit strobe; legal range 2..2^20.
- `clk_i` input 1: system clock.
- `rst_i` input 1: reset; asynchronous, active-low.
- `a_valid_i` input 1: requester A write request.
- `a_digit_i` input 3: target digit, 0..5.
- `a_value_i` input 4: hex value 0..F.
- `a_dp_i` input 1: decimal point on.
- `a_en_i` input 1: digit enabled; 0 means blank.
- `a_ready_o` output 1: A write accepted this cycle.
- `b_valid_i`, `b_digit_i`, `b_value_i`, `b_dp_i`, `b_en_i`, `b_ready_o`: same as the A port, for requester B.
- `scan_tick_o` output 1: one-cycle digit-advance strobe, connected to the scanner's `p1pps`.
- `scan_idx_o` output 3: digit currently being scanned, 0..5; mirrors the scanner's internal index.
- `frame_commit_o` output 1: one-cycle pulse in the cycle the shadow buffer is copied to the display buffer.
- `smg_1_o`..`smg_6_o` output 8 each: active-low segment pattern {dp,g,f,e,d,c,b,a}.

## Operation
- **Prescaler:** `div_cnt` counts 0..SCAN_DIV-1 and wraps. `scan_tick_o`=1 exactly in cycles where `div_cnt`==SCAN_DIV-1.
- **Scan index:** `scan_idx_o` advances on each tick and wraps 5→0.
- **Frame end:** a tick while `scan_idx_o`==5.
- **Arbitration:** combinational and round-robin, with priority pointer `ptr` (A or B).
  - `a_ready_o` = `a_valid_i` & (!`b_valid_i` | `ptr`==A).
  - `b_ready_o` = `b_valid_i` & (!`a_valid_i` | `ptr`==B).
  - At most one grant per cycle.
  - On a contended grant (both valid), `ptr` moves to the loser. On an uncontended grant, `ptr` is unchanged.
- **Shadow write:** an accepted write updates `shadow[digit]` = {en,dp,value} on the next edge and sets `dirty`.
  - `digit` > 5: write is accepted (ready=1) and dropped. `dirty` is not set.
- **Commit:** at frame end with `dirty`=1:
  - display buffer <= shadow.
  - `dirty` cleared.
  - `frame_commit_o`=1 in the same cycle as the tick.
  - At frame end with `dirty`=0: no commit and no pulse.
- **Encoding:**
  - en=0 → 8'hFF.
  - en=1 → hex pattern, with bit7 cleared when dp=1.
  - Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.

## Timing
- **Reset values:**
  - `div_cnt`=0, `scan_idx_o`=0, `ptr`=A, `dirty`=0.
  - All shadow and display entries are {en=0,dp=0,value=0}.
  - `smg_*_o`=8'hFF; `scan_tick_o`, `frame_commit_o`, and both ready outputs are 0 (ready stays 0 while the valids are 0).
- **Latency:**
  - Write accepted at cycle N → shadow updated at N+1.
  - Visible at `smg_k_o` one cycle after the next frame-end tick, because the outputs are registered encodes of the display buffer.
- **Write in the same cycle as a frame-end tick:** the commit copies the pre-write shadow. The new value waits for the next frame, and `dirty` remains 1.
- **Write in the cycle after a commit:** sets `dirty` again; committed at the next frame end.
- **Reset mid-frame:** all state returns to reset values immediately. Pending shadow data is lost.
- **Ready timing:** ready is combinational from valid; requesters hold their write fields stable while valid=1 and ready=0.

## Structure
- **Package `smg_pkg`:**
  - NUM_DIGITS=6.
  - SEG_BLANK=8'hFF.
  - Digit record type {en,dp,value[3:0]}.
  - The 16-entry hex segment constant set.
- **Sub-module `smg_seg_encode`:** combinational digit record → 8-bit pattern. Instantiated six times.
- **Top:** prescaler, scan index, arbiter with `ptr`, shadow/display buffers, and `dirty`/commit logic, in one module.

## Test plan
1. Reset, SCAN_DIV=4: `scan_tick_o` every 4th cycle, `scan_idx_o` 0,1,..,5,0. All `smg_*_o`=FF, no `frame_commit_o`.
2. A writes digit 2 = {en=1,dp=0,value=8}:
   - `a_ready_o`=1 the same cycle.
   - `smg_3_o`=80 one cycle after the next frame-end tick.
   - `frame_commit_o` pulses once; it does not pulse in the following frame.
3. A and B both valid for 4 cycles (digits 0 and 1): grants alternate A,B,A,B. After commit, `smg_1_o` and `smg_2_o` show the written values.
4. B writes digit 5 = {1,1,3} exactly on a frame-end tick: that commit excludes it. `smg_6_o`=30 appears only after the following frame end.
5. A writes digit 7: `a_ready_o`=1, no `dirty` set, no commit at frame end, outputs unchanged.
6. Assert `rst_i` low after shadow writes and before commit: outputs stay FF, `scan_idx_o`=0, and no commit ever shows the lost data.
